// File: rtl/div_issuer_if.sv
// Handshake bundle between upstream producer, divider controller and downstream consumer
// for div_issuer. The master modport is the issuer side; slave is the environment.
interface div_issuer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             op_valid;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ready;

  logic             div_start;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_ready;
  logic             div_error;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             div_abort;

  logic             res_valid;
  logic [WIDTH-1:0] res_quotient;
  logic [WIDTH-1:0] res_remainder;
  logic             res_error;
  logic             res_timeout;
  logic             res_ack;

  modport master (
    input  op_valid, op_a, op_b,
    output op_ready,
    output div_start, div_a, div_b, div_abort,
    input  div_ready, div_error, div_quotient, div_remainder,
    output res_valid, res_quotient, res_remainder, res_error, res_timeout,
    input  res_ack
  );

  modport slave (
    output op_valid, op_a, op_b,
    input  op_ready,
    input  div_start, div_a, div_b, div_abort,
    output div_ready, div_error, div_quotient, div_remainder,
    input  res_valid, res_quotient, res_remainder, res_error, res_timeout,
    output res_ack
  );
endinterface

// File: rtl/div_issuer.sv
// Issues one operand pair to a divider controller, waits for completion and holds the result
// until acknowledged. Define DIV_ISSUER_TIMEOUT_EN to enable the WAIT-state watchdog.
module div_issuer #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 300
) (
  input logic         i_clk,
  input logic         i_reset,
  div_issuer_if.master io_bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2,
    StHold   = 2'd3
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_accept;
  logic             w_capture;
  logic             w_expire;
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_b;
  logic [WIDTH-1:0] r_res_q;
  logic [WIDTH-1:0] r_res_r;
  logic             r_res_err;

`ifdef DIV_ISSUER_TIMEOUT_EN
  localparam logic [16:0] LP_LIMIT = 17'(TIMEOUT_CYCLES);
  logic [15:0] r_cnt;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        r_res_to;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_expire    = 1'b0;
`ifdef DIV_ISSUER_TIMEOUT_EN
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (io_bus.op_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = StLaunch;
        end
      end
      StLaunch: begin
        if (io_bus.div_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = StHold;
        end else begin
          w_state_nxt = StWait;
`ifdef DIV_ISSUER_TIMEOUT_EN
          w_cnt_clr   = 1'b1;
`endif
        end
      end
      StWait: begin
        // A completion in the expiry cycle takes priority over the watchdog.
        if (io_bus.div_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = StHold;
        end
`ifdef DIV_ISSUER_TIMEOUT_EN
        else if ({1'b0, r_cnt} + 17'd1 >= LP_LIMIT) begin
          w_expire    = 1'b1;
          w_state_nxt = StHold;
        end else begin
          w_cnt_inc   = 1'b1;
        end
`endif
      end
      StHold: begin
        if (io_bus.res_ack) w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_div_a   <= '0;
      r_div_b   <= '0;
      r_res_q   <= '0;
      r_res_r   <= '0;
      r_res_err <= 1'b0;
`ifdef DIV_ISSUER_TIMEOUT_EN
      r_cnt     <= '0;
      r_res_to  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_div_a <= io_bus.op_a;
        r_div_b <= io_bus.op_b;
      end
      if (w_capture) begin
        r_res_q   <= io_bus.div_error ? '0 : io_bus.div_quotient;
        r_res_r   <= io_bus.div_error ? '0 : io_bus.div_remainder;
        r_res_err <= io_bus.div_error;
`ifdef DIV_ISSUER_TIMEOUT_EN
        r_res_to  <= 1'b0;
`endif
      end
`ifdef DIV_ISSUER_TIMEOUT_EN
      if (w_expire) begin
        r_res_q   <= '0;
        r_res_r   <= '0;
        r_res_err <= 1'b1;
        r_res_to  <= 1'b1;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 16'd1;
      end
`endif
    end
  end

  assign io_bus.op_ready      = (r_state == StIdle);
  assign io_bus.div_start     = (r_state == StLaunch);
  assign io_bus.res_valid     = (r_state == StHold);
  assign io_bus.div_a         = r_div_a;
  assign io_bus.div_b         = r_div_b;
  assign io_bus.res_quotient  = r_res_q;
  assign io_bus.res_remainder = r_res_r;
  assign io_bus.res_error     = r_res_err;
  assign io_bus.div_abort     = w_expire;
`ifdef DIV_ISSUER_TIMEOUT_EN
  assign io_bus.res_timeout   = r_res_to;
`else
  assign io_bus.res_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_div_issuer.sv
// Directed bench for div_issuer: table of single operations plus stall, reset and watchdog
// sequences. The watchdog branch follows DIV_ISSUER_TIMEOUT_EN.
module tb_div_issuer;

  localparam int unsigned W  = 8;
  localparam int unsigned TO = 16;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  div_issuer_if #(.WIDTH(W)) bus ();

  div_issuer #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         n;   // cycles after LAUNCH before div_ready (0 = in LAUNCH)
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    logic [7:0] eq;
    logic [7:0] er;
    logic       ee;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_div();
    bus.div_ready     = 1'b0;
    bus.div_error     = 1'b0;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    chk("idle_op_ready", bus.op_ready, 1);
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    step();
    bus.op_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
  endtask

  task automatic ack();
    bus.res_ack = 1'b1;
    step();
    bus.res_ack = 1'b0;
    #1;
    chk("ack_res_valid", bus.res_valid, 0);
    chk("ack_op_ready", bus.op_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int starts;
    int early;
    starts = 0;
    early  = 0;
    accept(v.a, v.b);
    chk("div_a", bus.div_a, v.a);
    chk("div_b", bus.div_b, v.b);
    for (int c = 0; c <= v.n; c++) begin
      if (c == v.n) begin
        bus.div_ready     = 1'b1;
        bus.div_error     = v.err;
        bus.div_quotient  = v.q;
        bus.div_remainder = v.r;
      end
      #1;
      if (c == 0) chk("launch_start", bus.div_start, 1);
      starts += int'(bus.div_start);
      early  += int'(bus.res_valid) + int'(bus.op_ready);
      step();
    end
    clear_div();
    #1;
    chk("start_count", starts, 1);
    chk("busy_flags", early, 0);
    chk("hold_res_valid", bus.res_valid, 1);
    chk("hold_start", bus.div_start, 0);
    chk("res_quotient", bus.res_quotient, v.eq);
    chk("res_remainder", bus.res_remainder, v.er);
    chk("res_error", bus.res_error, v.ee);
    chk("res_timeout", bus.res_timeout, 0);
    ack();
    chk("post_ack_quotient", bus.res_quotient, v.eq);
  endtask

  initial begin
    int viol;
    int aborts;
    total = 0;
    bad   = 0;
    vecs[0] = '{a: 8'd100, b: 8'd7,  n: 15, q: 8'd14,  r: 8'd2,  err: 1'b0,
                eq: 8'd14,  er: 8'd2, ee: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd0,  n: 0,  q: 8'hAA,  r: 8'h55, err: 1'b1,
                eq: 8'd0,   er: 8'd0, ee: 1'b1};
    vecs[2] = '{a: 8'd3,   b: 8'd9,  n: 1,  q: 8'd0,   r: 8'd3,  err: 1'b0,
                eq: 8'd0,   er: 8'd3, ee: 1'b0};
    vecs[3] = '{a: 8'd200, b: 8'd16, n: 0,  q: 8'd12,  r: 8'd8,  err: 1'b0,
                eq: 8'd12,  er: 8'd8, ee: 1'b0};
    vecs[4] = '{a: 8'd255, b: 8'd1,  n: 3,  q: 8'd255, r: 8'd0,  err: 1'b0,
                eq: 8'd255, er: 8'd0, ee: 1'b0};
    vecs[5] = '{a: 8'd0,   b: 8'd0,  n: 2,  q: 8'h3C,  r: 8'hC3, err: 1'b1,
                eq: 8'd0,   er: 8'd0, ee: 1'b1};

    bus.op_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.res_ack  = 1'b0;
    clear_div();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rst_op_ready", bus.op_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_div_start", bus.div_start, 0);
    chk("rst_div_abort", bus.div_abort, 0);
    chk("rst_div_a", bus.div_a, 0);
    chk("rst_div_b", bus.div_b, 0);
    chk("rst_res_q", bus.res_quotient, 0);
    chk("rst_res_r", bus.res_remainder, 0);
    chk("rst_res_err", bus.res_error, 0);
    chk("rst_res_to", bus.res_timeout, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Result held for 10 cycles with op_valid high and stray div_ready; no new acceptance.
    accept(8'd50, 8'd5);
    bus.div_ready    = 1'b1;
    bus.div_quotient = 8'd10;
    step();
    clear_div();
    bus.op_valid = 1'b1;
    bus.op_a     = 8'd77;
    bus.op_b     = 8'd3;
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      bus.div_ready     = c[0];
      bus.div_error     = c[1];
      bus.div_quotient  = 8'd99;
      bus.div_remainder = 8'd98;
      #1;
      if (bus.res_valid !== 1'b1 || bus.op_ready !== 1'b0 || bus.res_quotient !== 8'd10 ||
          bus.res_remainder !== 8'd0 || bus.res_error !== 1'b0 || bus.div_a !== 8'd50)
        viol++;
      step();
    end
    clear_div();
    chk("stall_stable", viol, 0);
    bus.res_ack = 1'b1;
    step();
    bus.res_ack = 1'b0;
    #1;
    chk("ack_cycle_no_accept_a", bus.div_a, 8'd50);
    chk("ack_cycle_op_ready", bus.op_ready, 1);
    chk("ack_cycle_res_valid", bus.res_valid, 0);
    chk("ack_cycle_hold_q", bus.res_quotient, 8'd10);
    step();
    bus.op_valid = 1'b0;
    #1;
    chk("next_accept_start", bus.div_start, 1);
    chk("next_accept_a", bus.div_a, 8'd77);
    chk("next_accept_b", bus.div_b, 8'd3);
    bus.div_ready     = 1'b1;
    bus.div_quotient  = 8'd25;
    bus.div_remainder = 8'd2;
    step();
    clear_div();
    #1;
    chk("next_res_q", bus.res_quotient, 8'd25);
    chk("next_res_r", bus.res_remainder, 8'd2);
    ack();

    // Reset on the 5th WAIT cycle discards the operation.
    accept(8'd9, 8'd4);
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    #1;
    chk("midrst_op_ready", bus.op_ready, 1);
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_div_a", bus.div_a, 0);
    chk("midrst_div_b", bus.div_b, 0);
    viol = 0;
    bus.div_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      viol += int'(bus.res_valid) + int'(bus.div_start);
    end
    clear_div();
    chk("midrst_quiet", viol, 0);

`ifdef DIV_ISSUER_TIMEOUT_EN
    // Divider never completes: abort in the 16th WAIT cycle.
    accept(8'd60, 8'd6);
    bus.div_quotient = 8'hEE;
    step();
    aborts = 0;
    viol   = 0;
    for (int w = 1; w <= int'(TO); w++) begin
      #1;
      aborts += int'(bus.div_abort);
      if (w == int'(TO)) chk("abort_last_wait", bus.div_abort, 1);
      viol += int'(bus.res_valid);
      step();
    end
    clear_div();
    #1;
    chk("abort_count", aborts, 1);
    chk("to_waiting_res_valid", viol, 0);
    chk("to_res_valid", bus.res_valid, 1);
    chk("to_res_timeout", bus.res_timeout, 1);
    chk("to_res_error", bus.res_error, 1);
    chk("to_res_q", bus.res_quotient, 0);
    chk("to_res_r", bus.res_remainder, 0);
    chk("to_abort_hold", bus.div_abort, 0);
    ack();

    // Completion in the expiry cycle wins over the watchdog.
    accept(8'd60, 8'd6);
    step();
    aborts = 0;
    for (int w = 1; w <= int'(TO); w++) begin
      if (w == int'(TO)) begin
        bus.div_ready     = 1'b1;
        bus.div_quotient  = 8'd10;
        bus.div_remainder = 8'd0;
      end
      #1;
      aborts += int'(bus.div_abort);
      step();
    end
    clear_div();
    #1;
    chk("race_abort_count", aborts, 0);
    chk("race_res_valid", bus.res_valid, 1);
    chk("race_res_timeout", bus.res_timeout, 0);
    chk("race_res_error", bus.res_error, 0);
    chk("race_res_q", bus.res_quotient, 8'd10);
    ack();
`else
    // Without the watchdog WAIT is unbounded.
    accept(8'd60, 8'd6);
    step();
    viol   = 0;
    aborts = 0;
    for (int w = 0; w < 1000; w++) begin
      #1;
      viol   += int'(bus.res_valid) + int'(bus.op_ready) + int'(bus.div_start);
      aborts += int'(bus.div_abort);
      step();
    end
    chk("unbounded_wait", viol, 0);
    chk("no_abort", aborts, 0);
    bus.div_ready     = 1'b1;
    bus.div_quotient  = 8'd10;
    bus.div_remainder = 8'd0;
    step();
    clear_div();
    #1;
    chk("late_res_valid", bus.res_valid, 1);
    chk("late_res_q", bus.res_quotient, 8'd10);
    chk("late_res_timeout", bus.res_timeout, 0);
    ack();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
